// File: rtl/jtdd_pkg.sv
// rtl/jtdd_pkg.sv - shared constants and types for the colour mixer
package jtdd_pkg;

  // Palette geometry
  localparam int PAL_AW   = 9;
  localparam int PAL_DW   = 8;
  localparam int BANK_BIT = 9;

  // Layer prefixes forming the upper bits of the palette index
  localparam logic [1:0] CHAR_PREFIX = 2'b00;
  localparam logic [1:0] OBJ_PREFIX  = 2'b01;
  localparam logic       SCR_PREFIX  = 1'b1;

  // Pixel code that marks a layer as see-through
  localparam logic [3:0] TRANSP_CODE = 4'h0;

  typedef enum logic [1:0] {
    LAYER_CHAR = 2'd0,
    LAYER_OBJ  = 2'd1,
    LAYER_SCR  = 2'd2
  } layer_e;

  function automatic logic is_opaque(input logic [3:0] code);
    return code != TRANSP_CODE;
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// rtl/jtframe_dual_ram.sv - single-clock dual-port RAM, port 0 read/write, port 1 read-only
module jtframe_dual_ram #(
  parameter int    aw      = 9,
  parameter int    dw      = 8,
  parameter string SIMFILE = ""
) (
  input  logic          clk,
  // port 0: read/write
  input  logic [dw-1:0] data0,
  input  logic [aw-1:0] addr0,
  input  logic          we0,
  output logic [dw-1:0] q0,
  // port 1: read-only with clock enable
  input  logic          cen1,
  input  logic [aw-1:0] addr1,
  output logic [dw-1:0] q1
);

  logic [dw-1:0] mem_q [0:(1<<aw)-1];

  // Both reads sample the array before this edge's write lands, so a
  // same-cycle collision returns the old word on either port.
  always_ff @(posedge clk) begin
    if (we0) mem_q[addr0] <= data0;
    q0 <= mem_q[addr0];
    if (cen1) q1 <= mem_q[addr1];
  end

endmodule

// File: rtl/jtdd_colmix.sv
// rtl/jtdd_colmix.sv - layer priority mixer with CPU-writable RG/B palette banks
module jtdd_colmix
  import jtdd_pkg::*;
#(
  parameter string SIMFILE_LO = "pal_lo.bin",
  parameter string SIMFILE_HI = "pal_hi.bin"
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pxl_cen,
  input  logic       cen_E,
  input  logic       pal_cs,
  input  logic       cpu_wrn,
  input  logic [9:0] cpu_AB,
  input  logic [7:0] cpu_dout,
  output logic [7:0] pal_dout,
  input  logic [6:0] char_pxl,
  input  logic [6:0] obj_pxl,
  input  logic [7:0] scr_pxl,
  input  logic       LHBL,
  input  logic       LVBL,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);

  layer_e              layer_d;
  logic [PAL_AW-1:0]   idx_d, idx_q;
  logic                lhbl_q, lvbl_q;
  logic                lhbl_dly_q, lvbl_dly_q;
  logic                bank_q;
  logic                cpu_we, we_lo, we_hi;
  logic [PAL_DW-1:0]   cpu_lo, cpu_hi;
  logic [PAL_DW-1:0]   vid_rg, vid_b;
  logic                visible;
  logic                unused_b_hi;

  // Pick the front-most opaque layer; scroll is the backdrop
  always_comb begin
    layer_d = LAYER_SCR;
    if (is_opaque(char_pxl[3:0]))     layer_d = LAYER_CHAR;
    else if (is_opaque(obj_pxl[3:0])) layer_d = LAYER_OBJ;
  end

  // Form the palette index from the winning layer
  always_comb begin
    case (layer_d)
      LAYER_CHAR: idx_d = {CHAR_PREFIX, char_pxl};
      LAYER_OBJ:  idx_d = {OBJ_PREFIX, obj_pxl};
      default:    idx_d = {SCR_PREFIX, scr_pxl};
    endcase
  end

  // Stage 1: latch the index alongside the blanking inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      lhbl_q <= 1'b0;
      lvbl_q <= 1'b0;
    end else if (pxl_cen) begin
      idx_q  <= idx_d;
      lhbl_q <= LHBL;
      lvbl_q <= LVBL;
    end
  end

  // Stage 2: blanking follows the palette read so both land together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lhbl_dly_q <= 1'b0;
      lvbl_dly_q <= 1'b0;
    end else if (pxl_cen) begin
      lhbl_dly_q <= lhbl_q;
      lvbl_dly_q <= lvbl_q;
    end
  end

  // Remember which bank the CPU addressed so readback muxes the right port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bank_q <= 1'b0;
    else        bank_q <= cpu_AB[BANK_BIT];
  end

  assign cpu_we = pal_cs && !cpu_wrn && cen_E;
  assign we_lo  = cpu_we && !cpu_AB[BANK_BIT];
  assign we_hi  = cpu_we &&  cpu_AB[BANK_BIT];

  jtframe_dual_ram #(.aw(PAL_AW), .dw(PAL_DW), .SIMFILE(SIMFILE_LO)) u_pal_rg (
    .clk   (clk),
    .data0 (cpu_dout),
    .addr0 (cpu_AB[BANK_BIT-1:0]),
    .we0   (we_lo),
    .q0    (cpu_lo),
    .cen1  (pxl_cen),
    .addr1 (idx_q),
    .q1    (vid_rg)
  );

  jtframe_dual_ram #(.aw(PAL_AW), .dw(PAL_DW), .SIMFILE(SIMFILE_HI)) u_pal_b (
    .clk   (clk),
    .data0 (cpu_dout),
    .addr0 (cpu_AB[BANK_BIT-1:0]),
    .we0   (we_hi),
    .q0    (cpu_hi),
    .cen1  (pxl_cen),
    .addr1 (idx_q),
    .q1    (vid_b)
  );

  // Stage 3: split the palette words into channels, black while blanked.
  // Gating on the reset-cleared blanking flops blanks RGB the instant reset hits.
  assign visible  = lhbl_dly_q && lvbl_dly_q;
  assign red      = visible ? vid_rg[3:0] : 4'h0;
  assign green    = visible ? vid_rg[7:4] : 4'h0;
  assign blue     = visible ? vid_b[3:0]  : 4'h0;
  assign LHBL_dly = lhbl_dly_q;
  assign LVBL_dly = lvbl_dly_q;
  assign pal_dout = bank_q ? cpu_hi : cpu_lo;

  // Upper nibble of the B bank is CPU-visible storage only
  assign unused_b_hi = &{1'b0, vid_b[7:4]};

endmodule

// File: tb/tb_jtdd_colmix.sv
// tb/tb_jtdd_colmix.sv - self-checking bench for jtdd_colmix
module tb_jtdd_colmix;

  logic       clk = 1'b0;
  logic       rst_n, pxl_cen, cen_E, pal_cs, cpu_wrn;
  logic [9:0] cpu_AB;
  logic [7:0] cpu_dout, pal_dout;
  logic [6:0] char_pxl, obj_pxl;
  logic [7:0] scr_pxl;
  logic       LHBL, LVBL;
  logic [3:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;

  always #5 clk = ~clk;

  jtdd_colmix dut (
    .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .cen_E(cen_E),
    .pal_cs(pal_cs), .cpu_wrn(cpu_wrn), .cpu_AB(cpu_AB), .cpu_dout(cpu_dout),
    .pal_dout(pal_dout), .char_pxl(char_pxl), .obj_pxl(obj_pxl), .scr_pxl(scr_pxl),
    .LHBL(LHBL), .LVBL(LVBL), .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [6:0] c;
    logic [6:0] o;
    logic [7:0] s;
    logic       hb;
    logic       vb;
  } pix_t;

  logic [7:0]  rg_m [512];
  logic [7:0]  b_m  [512];
  pix_t        pend;
  logic [13:0] exp_out;
  logic [7:0]  exp_dout;
  logic        dout_valid;
  wire  [13:0] dut_out = {red, green, blue, LHBL_dly, LVBL_dly};

  // What the screen should show for a pixel, straight from the layer rules
  function automatic logic [13:0] model_video(input pix_t p);
    logic [8:0] idx;
    logic [3:0] r, g, b;
    if (p.c[3:0] != 4'h0)      idx = {2'b00, p.c};
    else if (p.o[3:0] != 4'h0) idx = {2'b01, p.o};
    else                       idx = {1'b1, p.s};
    r = rg_m[idx][3:0];
    g = rg_m[idx][7:4];
    b = b_m[idx][3:0];
    if (!(p.hb && p.vb)) begin r = 4'h0; g = 4'h0; b = 4'h0; end
    return {r, g, b, p.hb, p.vb};
  endfunction

  // One clk edge plus the reference model's view of it
  task automatic clk_cycle();
    @(posedge clk);
    exp_dout   = cpu_AB[9] ? b_m[cpu_AB[8:0]] : rg_m[cpu_AB[8:0]];
    dout_valid = rst_n;
    if (!rst_n) begin
      pend    = '0;
      exp_out = '0;
    end else if (pxl_cen) begin
      exp_out = model_video(pend);
      pend    = {char_pxl, obj_pxl, scr_pxl, LHBL, LVBL};
    end
    if (pal_cs && !cpu_wrn && cen_E) begin
      if (cpu_AB[9]) b_m[cpu_AB[8:0]]  = cpu_dout;
      else           rg_m[cpu_AB[8:0]] = cpu_dout;
    end
    #1;
  endtask

  task automatic tick();
    pxl_cen = 1'b1;
    clk_cycle();
    pxl_cen = 1'b0;
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
    pal_cs = 1'b1; cpu_wrn = 1'b0; cen_E = 1'b1; cpu_AB = a; cpu_dout = d;
    clk_cycle();
    pal_cs = 1'b0; cpu_wrn = 1'b1; cen_E = 1'b0;
  endtask

  task automatic set_pix(input logic [6:0] c, input logic [6:0] o, input logic [7:0] s);
    char_pxl = c; obj_pxl = o; scr_pxl = s; LHBL = 1'b1; LVBL = 1'b1;
  endtask

  task automatic test_reset();
    set_pix(7'h15, 7'h22, 8'hA5);
    pxl_cen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_cycle();
      n_checks++;
      if (dut_out !== 14'h0) begin
        n_fail++;
        $display("FAIL reset_hold: got %h expected %h", dut_out, 14'h0);
      end
    end
    pxl_cen = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (dut_out !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_first_tick: got %h expected %h", dut_out, 14'h0);
    end
  endtask

  task automatic test_cpu_fill();
    logic [7:0] d;
    for (int a = 0; a < 1024; a++) begin
      d = 8'($urandom);
      cpu_write(10'(a), d);
    end
    for (int i = 0; i < 24; i++) begin
      cpu_AB = 10'($urandom);
      clk_cycle();
      n_checks++;
      if (pal_dout !== exp_dout) begin
        n_fail++;
        $display("FAIL readback addr %h: got %h expected %h", cpu_AB, pal_dout, exp_dout);
      end
    end
  endtask

  task automatic test_write_gating();
    logic [9:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 10'($urandom);
      pal_cs = (i != 0); cpu_wrn = (i == 1); cen_E = (i != 2);
      cpu_AB = a; cpu_dout = ~(a[9] ? b_m[a[8:0]] : rg_m[a[8:0]]);
      clk_cycle();
      pal_cs = 1'b0; cpu_wrn = 1'b1; cen_E = 1'b0;
      clk_cycle();
      n_checks++;
      if (pal_dout !== exp_dout) begin
        n_fail++;
        $display("FAIL write_gating case %0d: got %h expected %h", i, pal_dout, exp_dout);
      end
    end
  endtask

  task automatic test_priority();
    cpu_write(10'h1A5, 8'h3C);
    cpu_write(10'h3A5, 8'h07);
    cpu_write(10'h015, 8'hF1);
    cpu_write(10'h215, 8'h02);
    cpu_write(10'h0FF, 8'h88);
    set_pix(7'h10, 7'h20, 8'hA5);
    tick(); tick();
    n_checks++;
    if (dut_out !== {12'hC37, 2'b11}) begin
      n_fail++;
      $display("FAIL scroll_fallback: got %h expected %h", dut_out, {12'hC37, 2'b11});
    end
    set_pix(7'h15, 7'h22, 8'($urandom));
    tick(); tick();
    n_checks++;
    if (dut_out !== {12'h1F2, 2'b11}) begin
      n_fail++;
      $display("FAIL char_over_obj: got %h expected %h", dut_out, {12'h1F2, 2'b11});
    end
    set_pix(7'h50, 7'h7F, 8'($urandom));
    tick(); tick();
    n_checks++;
    if ({red, green} !== 8'h88 || dut_out !== exp_out) begin
      n_fail++;
      $display("FAIL obj_over_scroll: got %h expected %h", dut_out, exp_out);
    end
  endtask

  task automatic test_blanking();
    logic [13:0] want;
    set_pix(7'h15, 7'h00, 8'h00);
    tick(); tick();
    for (int k = 0; k < 6; k++) begin
      LHBL = (k != 1);
      tick();
      want = (k == 2) ? 14'b01 : {12'h1F2, 2'b11};
      n_checks++;
      if (dut_out !== want) begin
        n_fail++;
        $display("FAIL blanking tick %0d: got %h expected %h", k, dut_out, want);
      end
    end
  endtask

  task automatic test_collision();
    cpu_write(10'h1A5, 8'h3C);
    set_pix(7'h10, 7'h20, 8'hA5);
    tick();
    pal_cs = 1'b1; cpu_wrn = 1'b0; cen_E = 1'b1; cpu_AB = 10'h1A5; cpu_dout = 8'h5A;
    tick();
    pal_cs = 1'b0; cpu_wrn = 1'b1; cen_E = 1'b0;
    n_checks++;
    if (dut_out !== {12'hC37, 2'b11}) begin
      n_fail++;
      $display("FAIL collision_old: got %h expected %h", dut_out, {12'hC37, 2'b11});
    end
    tick();
    n_checks++;
    if (dut_out !== {12'hA57, 2'b11}) begin
      n_fail++;
      $display("FAIL collision_new: got %h expected %h", dut_out, {12'hA57, 2'b11});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      char_pxl = 7'($urandom);
      obj_pxl  = 7'($urandom);
      scr_pxl  = 8'($urandom);
      if ($urandom_range(0, 1) == 0) char_pxl[3:0] = 4'h0;
      if ($urandom_range(0, 1) == 0) obj_pxl[3:0]  = 4'h0;
      LHBL     = ($urandom_range(0, 7) != 0);
      LVBL     = ($urandom_range(0, 7) != 0);
      pxl_cen  = ($urandom_range(0, 2) != 0);
      pal_cs   = ($urandom_range(0, 3) == 0);
      cpu_wrn  = ($urandom_range(0, 1) == 0);
      cen_E    = ($urandom_range(0, 1) == 0);
      cpu_AB   = 10'($urandom);
      cpu_dout = 8'($urandom);
      clk_cycle();
      n_checks++;
      if (dut_out !== exp_out) begin
        n_fail++;
        $display("FAIL random_video step %0d: got %h expected %h", i, dut_out, exp_out);
      end
      n_checks++;
      if (dout_valid && pal_dout !== exp_dout) begin
        n_fail++;
        $display("FAIL random_readback step %0d: got %h expected %h", i, pal_dout, exp_dout);
      end
    end
    pxl_cen = 1'b0; pal_cs = 1'b0; cpu_wrn = 1'b1; cen_E = 1'b0;
  endtask

  task automatic test_reset_mid();
    set_pix(7'h15, 7'h22, 8'hA5);
    tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_out !== 14'h0) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected %h", dut_out, 14'h0);
    end
    pxl_cen = 1'b1;
    clk_cycle(); clk_cycle();
    pxl_cen = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cpu_AB = 10'($urandom);
      clk_cycle();
      n_checks++;
      if (pal_dout !== exp_dout) begin
        n_fail++;
        $display("FAIL reset_palette_kept addr %h: got %h expected %h", cpu_AB, pal_dout, exp_dout);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (dut_out !== exp_out || (i == 0 && dut_out !== 14'h0)) begin
        n_fail++;
        $display("FAIL reset_recovery tick %0d: got %h expected %h", i, dut_out, exp_out);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; pxl_cen = 1'b0; cen_E = 1'b0; pal_cs = 1'b0; cpu_wrn = 1'b1;
    cpu_AB = '0; cpu_dout = '0; char_pxl = '0; obj_pxl = '0; scr_pxl = '0;
    LHBL = 1'b0; LVBL = 1'b0;
    pend = '0; exp_out = '0; exp_dout = '0; dout_valid = 1'b0;
    #2;
    test_reset();
    test_cpu_fill();
    test_write_gating();
    test_priority();
    test_blanking();
    test_collision();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jtdd_colmix.md
JTDD_COLMIX -- requirements
Module: jtdd_colmix

Interface
REQ-001 Parameter SIMFILE_LO, default "pal_lo.bin", initial content of the RG palette bank in simulation.
REQ-002 Parameter SIMFILE_HI, default "pal_hi.bin", initial content of the B palette bank in simulation.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 pxl_cen  in  1  pixel clock enable.
REQ-006 cen_E  in  1  CPU E-phase enable for palette writes.
REQ-007 pal_cs  in  1  CPU palette chip select.
REQ-008 cpu_wrn  in  1  CPU write strobe, active-low.
REQ-009 cpu_AB  in  10  CPU address; bit 9 selects the bank (0 = RG, 1 = B), bits 8:0 are the colour index.
REQ-010 cpu_dout  in  8  CPU write data.
REQ-011 pal_dout  out  8  CPU read data from the addressed bank.
REQ-012 char_pxl  in  7  char layer pixel {pal[2:0], code[3:0]}.
REQ-013 obj_pxl  in  7  object layer pixel {pal[2:0], code[3:0]}.
REQ-014 scr_pxl  in  8  scroll layer pixel {pal[3:0], code[3:0]}.
REQ-015 LHBL, LVBL  in  1 each  horizontal and vertical blanking, active-low.
REQ-016 red, green, blue  out  4 each  final colour.
REQ-017 LHBL_dly, LVBL_dly  out  1 each  blanking delayed to align with RGB.

Function
REQ-018 Transparency: a layer SHALL be transparent when its code[3:0] equals 0.
REQ-019 Priority: char SHALL win over obj, and obj SHALL win over scroll; scroll SHALL always be drawn when both char and obj are transparent.
REQ-020 The 9-bit palette index SHALL be {2'b00, char_pxl} for char, {2'b01, obj_pxl} for obj and {1'b1, scr_pxl} for scroll.
REQ-021 Stage 1, on pxl_cen: select the index and register it together with LHBL and LVBL.
REQ-022 Stage 2, on pxl_cen: read both palette banks at the registered index and shift the blanking signals again.
REQ-023 Stage 3, on pxl_cen: red = RG[3:0], green = RG[7:4], blue = B[3:0].
REQ-024 RGB SHALL be forced to 0 when the delayed blanking signal (LHBL && LVBL) is low.
REQ-025 Total latency from pixel inputs to RGB SHALL be exactly 2 pxl_cen ticks; LHBL_dly and LVBL_dly SHALL carry the same delay.
REQ-026 All registers SHALL hold their value while pxl_cen is low.
REQ-027 CPU write: when pal_cs && !cpu_wrn && cen_E, cpu_dout SHALL be written to the bank selected by cpu_AB[9] at cpu_AB[8:0].
REQ-028 The CPU port and the video port SHALL be independent; the CPU SHALL never stall.
REQ-029 Simultaneous CPU write and video read of the same entry SHALL return the old data to video; the new data SHALL appear from the next read.
REQ-030 pal_dout SHALL present bank[cpu_AB[9]][cpu_AB[8:0]] one clk after the address is stable.
REQ-031 B[7:4] SHALL be stored and read back by the CPU, and SHALL be ignored for video.

Reset
REQ-032 On rst_n low: red, green and blue SHALL be 0.
REQ-033 On rst_n low: LHBL_dly and LVBL_dly SHALL be 0.
REQ-034 On rst_n low: the pipeline index registers SHALL be 0.
REQ-035 Palette RAM contents SHALL NOT be cleared by reset.
REQ-036 Deassertion SHALL be honoured on the next clk; the first valid RGB follows two pxl_cen ticks after deassertion.
REQ-037 Reset asserted mid-line SHALL immediately blank the outputs; the block SHALL need no further recovery.

Structure
REQ-038 Layer index prefixes (2'b00, 2'b01, 1'b1), the transparent code value (4'h0) and the bank-select bit position SHALL live in the shared package jtdd_pkg.
REQ-039 Each palette bank SHALL be one instance of the sub-module jtframe_dual_ram (aw = 9, dw = 8): port 0 is CPU read/write, port 1 is video read-only.
REQ-040 Target size is 120-250 lines of RTL.

Verification
REQ-041 Transparency and scroll fallback: write RG[0x1A5] = 0x3C and B[0x1A5] = 0x07, apply char_pxl = 0x10, obj_pxl = 0x20, scr_pxl = 0xA5 -> two ticks later RGB = (C, 3, 7).
REQ-042 Char over obj: char_pxl = 0x15, obj_pxl = 0x22, with RG[0x015] = 0xF1 and B[0x015] = 0x02 -> RGB = (1, F, 2).
REQ-043 Obj over scroll: char code 0, obj_pxl = 0x7F, with RG[0x0FF] = 0x88 -> red = 8, green = 8.
REQ-044 Blanking: LHBL low for 1 tick with valid pixels -> RGB = 0 and LHBL_dly low, exactly 2 ticks later, for exactly 1 tick.
REQ-045 Write/read collision: CPU writes index 0x1A5 in the same clk as the video read of 0x1A5 -> old colour is output, and the new colour is output on the following pixel.
REQ-046 Reset mid-frame: rst_n pulled low -> RGB = 0 and LHBL_dly = LVBL_dly = 0 immediately; palette readback via pal_dout is unchanged after release.
